// File: rtl/gray_stim_pkg.sv
// Shared state encoding and Gray-code helper for the Gray stimulus sequencer.
package gray_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] x);
    return x ^ (x >> 1);
  endfunction

endpackage

// File: rtl/gray_adj_check.sv
// Gray adjacency checker: flags any accepted vector that is not exactly one bit
// away from the previously accepted vector of the same sweep.
module gray_adj_check #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] vec,
  output logic         err
);

  logic [W-1:0] prev;
  logic         have_prev;
  logic         bad_c;

  always_comb bad_c = ($countones(prev ^ vec) != 1);

  // First accept of a sweep only seeds prev; later accepts are compared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev      <= '0;
      have_prev <= 1'b0;
      err       <= 1'b0;
    end else if (clr) begin
      have_prev <= 1'b0;
      err       <= 1'b0;
    end else if (en) begin
      if (have_prev && bad_c) err <= 1'b1;
      prev      <= vec;
      have_prev <= 1'b1;
    end
  end

endmodule

// File: rtl/gray_stim_seq.sv
// Gray-code stimulus sequencer: sweeps all 2^W input vectors over a valid/ready
// handshake and assembles the downstream truth table.
// Optional adjacency checker enabled by defining GRAY_STIM_CHECK_EN.
module gray_stim_seq
  import gray_stim_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ready,
  input  logic              resp,
  output logic              valid,
  output logic [W-1:0]      vec,
  output logic [W-1:0]      idx,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic [(1<<W)-1:0] tt,
  output logic              err
);

  localparam int unsigned N       = 32'(1) << W;
  localparam logic [W-1:0] IDX_MAX = W'(N - 1);

  state_t         state, state_d;
  logic           valid_d, done_d;
  logic [W-1:0]   vec_d, idx_d, idx_nxt;
  logic [N-1:0]   tt_d;
  logic           accept, start_sweep;

  assign accept      = (state == RUN) && valid && ready;
  assign start_sweep = (state == IDLE) && start;
  assign idx_nxt     = idx + W'(1);

  // Next-state and datapath updates; registered below.
  always_comb begin
    state_d = state;
    valid_d = valid;
    vec_d   = vec;
    idx_d   = idx;
    done_d  = 1'b0;
    tt_d    = tt;
    case (state)
      IDLE: begin
        if (start_sweep) begin
          state_d = RUN;
          valid_d = 1'b1;
          vec_d   = '0;
          idx_d   = '0;
          tt_d    = '0;
        end
      end
      RUN: begin
        if (accept) begin
          tt_d[vec] = resp;
          if (idx == IDX_MAX) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d = idx_nxt;
            vec_d = W'(bin2gray(32'(idx_nxt)));
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      valid <= 1'b0;
      vec   <= '0;
      idx   <= '0;
      done  <= 1'b0;
      tt    <= '0;
      busy  <= 1'b0;
      last  <= 1'b0;
    end else begin
      state <= state_d;
      valid <= valid_d;
      vec   <= vec_d;
      idx   <= idx_d;
      done  <= done_d;
      tt    <= tt_d;
      busy  <= (state_d != IDLE);
      last  <= valid_d && (idx_d == IDX_MAX);
    end
  end

`ifdef GRAY_STIM_CHECK_EN
  gray_adj_check #(.W(W)) u_adj_check (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_sweep),
    .en    (accept),
    .vec   (vec),
    .err   (err)
  );
`else
  assign err = 1'b0;
`endif

endmodule
